// File: rtl/i2c_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : i2c_pkg
//  Description : Shared types and constants for the I2C target block:
//                FSM state encoding, R/W bit values and ACK/NACK levels.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    // Protocol FSM states (explicit 3-bit encoding)
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_WRITE     = 3'd3,
        ST_WRITE_ACK = 3'd4,
        ST_READ      = 3'd5,
        ST_READ_ACK  = 3'd6,
        ST_IGNORE    = 3'd7
    } i2c_state_t;

    // R/W bit (LSB of the address byte)
    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;

    // Acknowledge bit level on SDA during the 9th SCL period
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage : i2c_pkg
`default_nettype wire

// File: rtl/i2c_sync_filter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : i2c_sync_filter
//  Description : Two-flop synchroniser followed by a stability filter. A new
//                level is accepted only after it has been seen for
//                FILTER_LEN consecutive CLK cycles. Resets to 1 (idle bus).
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_sync_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic CLK,
    input  logic rst,
    input  logic i_raw,
    output logic o_level
);

    localparam int C_CNT_W = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

    logic [1:0]         r_sync;
    logic [C_CNT_W-1:0] r_cnt;
    logic               r_level;

    // Synchronise the pad, then count how long it has disagreed with the accepted level
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_sync  <= 2'b11;
            r_cnt   <= '0;
            r_level <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == C_CNT_W'(FILTER_LEN - 1)) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;

endmodule : i2c_sync_filter
`default_nettype wire

// File: rtl/i2c_target.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : i2c_target
//  Description : I2C target (slave) with a fixed 7-bit address. Received
//                bytes appear on wr_data/wr_valid; transmit bytes are
//                requested with rd_req and taken from rd_data one CLK later.
//                No clock stretching; SDA is open-drain via sda_oe.
//  Options     : define I2C_TARGET_READ_EN to enable controller reads;
//                otherwise a read address is NACKed and ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR       = 7'h2F,
    parameter int         FILTER_LEN = 4
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] wr_data,
    output logic       wr_valid,
    output logic       rd_req,
    input  logic [7:0] rd_data,
    output logic       busy
);

    logic w_scl_f;
    logic w_sda_f;

    i2c_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .CLK     (CLK),
        .rst     (rst),
        .i_raw   (scl_in),
        .o_level (w_scl_f)
    );

    i2c_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .CLK     (CLK),
        .rst     (rst),
        .i_raw   (sda_in),
        .o_level (w_sda_f)
    );

    logic r_scl_d;
    logic r_sda_d;

    // Previous filtered levels for edge and START/STOP detection
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_scl_d <= 1'b1;
            r_sda_d <= 1'b1;
        end else begin
            r_scl_d <= w_scl_f;
            r_sda_d <= w_sda_f;
        end
    end

    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    assign w_scl_rise = w_scl_f & ~r_scl_d;
    assign w_scl_fall = ~w_scl_f & r_scl_d;
    assign w_start    = w_scl_f & r_scl_d & r_sda_d & ~w_sda_f;
    assign w_stop     = w_scl_f & r_scl_d & ~r_sda_d & w_sda_f;

    i2c_state_t r_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_byte_full;   // 8 bits have been clocked; act on the next SCL fall
    logic       r_rw;
    logic       r_sda_oe;
    logic [7:0] r_wr_data;
    logic       r_wr_valid;
    logic       r_busy;

    logic w_addr_match;
    assign w_addr_match = (r_shift[7:1] == ADDR);

`ifdef I2C_TARGET_READ_EN
    logic [7:0] r_tx;
    logic       r_rd_req;
    logic       r_ack_ok;

    // Capture the transmit byte one CLK after the request pulse
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_tx <= 8'h00;
        end else if (r_rd_req) begin
            r_tx <= rd_data;
        end
    end
`else
    logic w_unused_rd_data;
    assign w_unused_rd_data = ^rd_data;
`endif

    // Protocol FSM: START/STOP override everything, bits move on filtered SCL edges
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'h00;
            r_byte_full <= 1'b0;
            r_rw        <= I2C_WRITE;
            r_sda_oe    <= 1'b0;
            r_wr_data   <= 8'h00;
            r_wr_valid  <= 1'b0;
            r_busy      <= 1'b0;
`ifdef I2C_TARGET_READ_EN
            r_rd_req    <= 1'b0;
            r_ack_ok    <= 1'b0;
`endif
        end else begin
            r_wr_valid <= 1'b0;
`ifdef I2C_TARGET_READ_EN
            r_rd_req   <= 1'b0;
`endif
            if (w_start || w_stop) begin
                // A repeated START drops any partial byte; STOP ends the transfer
                r_state     <= w_start ? ST_ADDR : ST_IDLE;
                r_bit_cnt   <= 3'd0;
                r_byte_full <= 1'b0;
                r_sda_oe    <= 1'b0;
                r_busy      <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_sda_oe <= 1'b0;
                    end

                    ST_ADDR, ST_WRITE: begin
                        if (w_scl_rise) begin
                            r_shift   <= {r_shift[6:0], w_sda_f};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_byte_full <= 1'b1;
                            end
                        end else if (w_scl_fall && r_byte_full) begin
                            r_byte_full <= 1'b0;
                            if (r_state == ST_ADDR) begin
                                r_rw <= r_shift[0];
                                if (!w_addr_match) begin
                                    r_state <= ST_IGNORE;
                                end else if (r_shift[0] == I2C_WRITE) begin
                                    r_busy   <= 1'b1;
                                    r_state  <= ST_ADDR_ACK;
                                    r_sda_oe <= 1'b1;
                                end else begin
                                    r_busy <= 1'b1;
`ifdef I2C_TARGET_READ_EN
                                    r_state  <= ST_ADDR_ACK;
                                    r_sda_oe <= 1'b1;
                                    r_rd_req <= 1'b1;
`else
                                    r_state  <= ST_IGNORE;
`endif
                                end
                            end else begin
                                r_wr_data  <= r_shift;
                                r_wr_valid <= 1'b1;
                                r_sda_oe   <= 1'b1;
                                r_state    <= ST_WRITE_ACK;
                            end
                        end
                    end

                    ST_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            r_bit_cnt <= 3'd0;
                            if (r_rw == I2C_WRITE) begin
                                r_state  <= ST_WRITE;
                                r_sda_oe <= 1'b0;
                            end else begin
`ifdef I2C_TARGET_READ_EN
                                r_state  <= ST_READ;
                                r_sda_oe <= ~r_tx[7];
`else
                                r_state  <= ST_IGNORE;
                                r_sda_oe <= 1'b0;
`endif
                            end
                        end
                    end

                    ST_WRITE_ACK: begin
                        if (w_scl_fall) begin
                            r_state  <= ST_WRITE;
                            r_sda_oe <= 1'b0;
                        end
                    end

`ifdef I2C_TARGET_READ_EN
                    ST_READ: begin
                        if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_byte_full <= 1'b1;
                            end
                        end else if (w_scl_fall) begin
                            if (r_byte_full) begin
                                // Release SDA so the controller can ACK/NACK
                                r_byte_full <= 1'b0;
                                r_sda_oe    <= 1'b0;
                                r_ack_ok    <= 1'b0;
                                r_state     <= ST_READ_ACK;
                            end else begin
                                r_sda_oe <= ~r_tx[3'd7 - r_bit_cnt];
                            end
                        end
                    end

                    ST_READ_ACK: begin
                        if (w_scl_rise) begin
                            // Request early so the next byte is ready by the SCL fall
                            if (w_sda_f == ACK) begin
                                r_ack_ok <= 1'b1;
                                r_rd_req <= 1'b1;
                            end else begin
                                r_ack_ok <= 1'b0;
                            end
                        end else if (w_scl_fall) begin
                            r_bit_cnt <= 3'd0;
                            if (r_ack_ok) begin
                                r_state  <= ST_READ;
                                r_sda_oe <= ~r_tx[7];
                            end else begin
                                r_state  <= ST_IGNORE;
                                r_sda_oe <= 1'b0;
                            end
                        end
                    end
`else
                    ST_READ, ST_READ_ACK: begin
                        r_state  <= ST_IGNORE;
                        r_sda_oe <= 1'b0;
                    end
`endif

                    ST_IGNORE: begin
                        r_sda_oe <= 1'b0;
                    end

                    default: begin
                        r_state  <= ST_IDLE;
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_oe   = r_sda_oe;
    assign wr_data  = r_wr_data;
    assign wr_valid = r_wr_valid;
    assign busy     = r_busy;
`ifdef I2C_TARGET_READ_EN
    assign rd_req   = r_rd_req;
`else
    assign rd_req   = 1'b0;
`endif

endmodule : i2c_target
`default_nettype wire

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter ADDR, default 7'h2F, the 7-bit target address it responds to.
REQ-002 SHALL have parameter FILTER_LEN, default 4, the number of CLK cycles a synchronised SCL/SDA level must hold before it is accepted.
REQ-003 SHALL have port CLK, input, 1 bit: the single system clock (16 MHz).
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port scl_in, input, 1 bit: raw SCL pad input.
REQ-006 SHALL have port sda_in, input, 1 bit: raw SDA pad input.
REQ-007 SHALL have port sda_oe, output, 1 bit: 1 drives SDA low; the pad output data is tied 0.
REQ-008 SHALL have port wr_data, output, 8 bits: last byte received from the controller.
REQ-009 SHALL have port wr_valid, output, 1 bit: one-cycle pulse when wr_data updates.
REQ-010 SHALL have port rd_req, output, 1 bit: one-cycle pulse requesting the next read byte.
REQ-011 SHALL have port rd_data, input, 8 bits: byte to transmit; sampled 1 CLK after rd_req.
REQ-012 SHALL have port busy, output, 1 bit: 1 from an address match until STOP or START.

Function
REQ-013 SHALL pass scl_in/sda_in through a 2-flop synchroniser and then a FILTER_LEN stability filter; all logic SHALL use the filtered levels (scl_f, sda_f) and their edges.
REQ-014 SHALL detect START as sda_f falling while scl_f=1, and STOP as sda_f rising while scl_f=1.
REQ-015 SHALL implement states IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE.
REQ-016 SHALL go to ADDR on START from any state (repeated START) and discard any partial byte; SHALL go to IDLE on STOP from any state; SHALL release sda_oe in both cases.
REQ-017 SHALL sample SDA on scl_f rising edges only and change sda_oe only on the CLK following a scl_f falling edge.
REQ-018 SHALL shift bits MSB first using a 3-bit bit counter that wraps 7->0 at byte end.
REQ-019 ADDR: after 8 bits, if addr[7:1]==ADDR then ADDR_ACK with sda_oe=1 for the 9th SCL period; otherwise IGNORE with sda_oe held 0.
REQ-020 ADDR_ACK SHALL go to WRITE if R/W=0 and to READ if R/W=1; for a read, rd_req SHALL pulse on the scl_f falling edge that starts the ACK period.
REQ-021 WRITE: after 8 bits, wr_data SHALL load the byte, wr_valid SHALL pulse, and the 9th period SHALL be ACKed (WRITE_ACK); the block SHALL return to WRITE for unlimited further bytes.
REQ-022 READ: the byte captured from rd_data SHALL be driven with sda_oe = ~bit, starting at the falling edge that ends ADDR_ACK/READ_ACK; sda_oe SHALL be 0 during the 9th period.
REQ-023 READ_ACK: controller ACK (sda_f=0) SHALL pulse rd_req and return to READ; NACK SHALL go to IGNORE.
REQ-024 IGNORE SHALL never assert sda_oe, wr_valid or rd_req.
REQ-025 Clock stretching is not supported; SCL is never driven.

Reset
REQ-026 On rst=1 at a CLK edge: state=IDLE, sda_oe=0, wr_data=0, wr_valid=0, rd_req=0, busy=0, bit counter=0, filters preset to 1 (bus idle); this SHALL hold mid-transfer, including during an ACK.

Configuration
REQ-027 With I2C_TARGET_READ_EN defined, reads SHALL behave per REQ-020..023; without it, an address match with R/W=1 SHALL be NACKed and go to IGNORE, rd_req SHALL stay 0, and rd_data SHALL be unused.

Structure
REQ-028 A shared package i2c_pkg SHALL hold the state enum, the I2C_WRITE=0/I2C_READ=1 constants and the ACK=0/NACK=1 constants.
REQ-029 Synchroniser plus filter SHALL be one sub-module, i2c_sync_filter, instantiated once per line.

Verification (CLK 16 MHz, SCL 100 kHz)
REQ-030 START, 0x5E (0x2F+W), 0x0A, STOP -> ACK on both bytes; wr_valid pulses once with wr_data=0x0A; busy falls after STOP.
REQ-031 START, 0x60 (addr 0x30+W), 0x55 -> sda_oe never 1; no wr_valid.
REQ-032 READ_EN defined, rd_data=0xA5, START, 0x5F, controller ACK, then NACK -> bits 10100101 twice; rd_req pulses twice; SDA released after NACK.
REQ-033 Repeated START after 4 data bits, then 0x5E, 0x33 -> partial byte dropped; one wr_valid with 0x33.
REQ-034 rst pulsed during ADDR_ACK -> sda_oe=0 on the next CLK; the next full write ACKs normally.
REQ-035 READ_EN undefined, START, 0x5F -> NACK, rd_req stays 0, state IGNORE until STOP.
